// File: rtl/exec_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : exec_alu_if
// Description : Handshake/data bundle between the issue register, the
//               Execute-stage ALU and the writeback stage.
//               Issue side : in_valid / in_ready / in_op / in_a / in_b
//               Result side: out_valid / out_ready / out_result /
//                            out_flags {negative, overflow, carry, zero} /
//                            out_illegal
//               slave  modport : used by the ALU
//               master modport : used by the issue/writeback side
// Revision    : 1.0 - initial release
// ============================================================================
interface exec_alu_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [3:0]      out_flags;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_flags, out_illegal
  );

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_flags, out_illegal
  );
endinterface
`default_nettype wire

// File: rtl/exec_alu.sv
`default_nettype none
// ============================================================================
// Module      : exec_alu
// Description : Execute-stage ALU. Single-cycle ADD/SUB/AND/OR/XOR/SLL/SRL/
//               SRA/SLT/SLTU; optional iterative unsigned MUL/MULHU/DIVU/REMU
//               (one bit per cycle, XLEN iterations).
//               Build option: define EXEC_ALU_MULDIV_EN to implement opcodes
//               10-13; otherwise they are reported as illegal in one cycle.
// Ports       : clock  - rising-edge clock
//               reset  - synchronous active-high reset
//               io_bus - exec_alu_if.slave (issue and result handshakes);
//                        its XLEN must match this module's XLEN
// Revision    : 1.0 - initial release
// ============================================================================
module exec_alu #(
  parameter int XLEN = 32
) (
  input  logic       clock,
  input  logic       reset,
  exec_alu_if.slave  io_bus
);
  localparam int c_SHW  = $clog2(XLEN);
  localparam int c_CNTW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_out_valid;
  logic [XLEN-1:0] r_result;
  logic [3:0]      r_flags;
  logic            r_illegal;

  logic            w_in_ready;
  logic            w_accept;
  logic [XLEN:0]   w_sum;
  logic [XLEN-1:0] w_diff;
  logic [c_SHW-1:0] w_shamt;
  logic [XLEN-1:0] w_res;
  logic            w_c;
  logic            w_v;
  logic            w_illegal;
  logic [3:0]      w_flags;
  logic            w_start_mul;
  logic            w_start_div;
  logic            w_last;
  logic [XLEN-1:0] w_md_res;

  // Ready is gated by reset so nothing is accepted on the reset edge.
  assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || io_bus.out_ready) && !reset;
  assign w_accept   = io_bus.in_valid && w_in_ready;

  assign w_sum   = {1'b0, io_bus.in_a} + {1'b0, io_bus.in_b};
  assign w_diff  = io_bus.in_a - io_bus.in_b;
  assign w_shamt = io_bus.in_b[c_SHW-1:0];

  // Single-cycle datapath and multi-cycle op decode.
  always_comb begin
    w_res       = '0;
    w_c         = 1'b0;
    w_v         = 1'b0;
    w_illegal   = 1'b0;
    w_start_mul = 1'b0;
    w_start_div = 1'b0;
    case (io_bus.in_op)
      4'd0: begin
        w_res = w_sum[XLEN-1:0];
        w_c   = w_sum[XLEN];
        w_v   = (io_bus.in_a[XLEN-1] == io_bus.in_b[XLEN-1]) &&
                (w_sum[XLEN-1] != io_bus.in_a[XLEN-1]);
      end
      4'd1: begin
        w_res = w_diff;
        w_c   = (io_bus.in_a >= io_bus.in_b);   // no-borrow
        w_v   = (io_bus.in_a[XLEN-1] != io_bus.in_b[XLEN-1]) &&
                (w_diff[XLEN-1] != io_bus.in_a[XLEN-1]);
      end
      4'd2: w_res = io_bus.in_a & io_bus.in_b;
      4'd3: w_res = io_bus.in_a | io_bus.in_b;
      4'd4: w_res = io_bus.in_a ^ io_bus.in_b;
      4'd5: w_res = io_bus.in_a << w_shamt;
      4'd6: w_res = io_bus.in_a >> w_shamt;
      4'd7: w_res = $unsigned($signed(io_bus.in_a) >>> w_shamt);
      4'd8: w_res = {{(XLEN-1){1'b0}}, ($signed(io_bus.in_a) < $signed(io_bus.in_b))};
      4'd9: w_res = {{(XLEN-1){1'b0}}, (io_bus.in_a < io_bus.in_b)};
`ifdef EXEC_ALU_MULDIV_EN
      4'd10, 4'd11: w_start_mul = 1'b1;
      4'd12, 4'd13: w_start_div = 1'b1;
`endif
      default: w_illegal = 1'b1;
    endcase
    // Illegal ops leave w_res at 0, so this yields {0,0,0,1} for them.
    w_flags = {w_res[XLEN-1], w_v, w_c, (w_res == '0)};
  end

`ifdef EXEC_ALU_MULDIV_EN
  // Shared accumulator: MUL keeps {partial product, remaining multiplier},
  // DIV keeps {partial remainder, dividend bits / quotient bits}.
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opb;
  logic              r_hi_sel;
  logic [c_CNTW-1:0] r_cnt;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_div_trial;
  logic [2*XLEN-1:0] w_acc_next;

  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    // Shifted remainder minus divisor; bit XLEN set means borrow (restore).
    // With a zero divisor every trial succeeds, so the quotient becomes all
    // ones and the dividend shifts through unchanged into the remainder.
    w_div_trial = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opb};
    if (r_state == S_MUL)
      w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
    else if (!w_div_trial[XLEN])
      w_acc_next = {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    else
      w_acc_next = {r_acc[2*XLEN-2:0], 1'b0};
    w_last   = (r_state != S_IDLE) && (r_cnt == c_CNTW'(XLEN - 1));
    w_md_res = r_hi_sel ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc    <= '0;
      r_opb    <= '0;
      r_hi_sel <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept && w_start_mul) begin
      r_acc    <= {{XLEN{1'b0}}, io_bus.in_b};
      r_opb    <= io_bus.in_a;
      r_hi_sel <= io_bus.in_op[0];   // MULHU selects the high half
      r_cnt    <= '0;
    end else if (w_accept && w_start_div) begin
      r_acc    <= {{XLEN{1'b0}}, io_bus.in_a};
      r_opb    <= io_bus.in_b;
      r_hi_sel <= io_bus.in_op[0];   // REMU selects the remainder half
      r_cnt    <= '0;
    end else if (r_state != S_IDLE) begin
      r_acc <= w_acc_next;
      r_cnt <= w_last ? '0 : r_cnt + c_CNTW'(1);
    end
  end
`else
  assign w_last   = 1'b0;
  assign w_md_res = '0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_start_mul)      w_state_next = S_MUL;
        else if (w_accept && w_start_div) w_state_next = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (w_last) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_illegal   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept && !w_start_mul && !w_start_div) begin
        r_result    <= w_res;
        r_flags     <= w_flags;
        r_illegal   <= w_illegal;
        r_out_valid <= 1'b1;
      end else if (w_last) begin
        r_result    <= w_md_res;
        r_flags     <= {w_md_res[XLEN-1], 1'b0, 1'b0, (w_md_res == '0)};
        r_illegal   <= 1'b0;
        r_out_valid <= 1'b1;
      end else if (io_bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign io_bus.in_ready    = w_in_ready;
  assign io_bus.out_valid   = r_out_valid;
  assign io_bus.out_result  = r_result;
  assign io_bus.out_flags   = r_flags;
  assign io_bus.out_illegal = r_illegal;
endmodule
`default_nettype wire

// File: tb/tb_exec_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_alu
// Description : Directed self-checking bench for exec_alu (XLEN=32).
//               Expectations for opcodes 10-13 follow EXEC_ALU_MULDIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_alu;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  exec_alu_if #(.XLEN(XLEN)) bus ();

  exec_alu #(.XLEN(XLEN)) dut (
    .clock  (clk),
    .reset  (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] res, input logic [3:0] flg,
                         input logic ill);
    chk({tag, "_valid"},   64'(bus.out_valid),   64'(1'b1));
    chk({tag, "_result"},  64'(bus.out_result),  64'(res));
    chk({tag, "_flags"},   64'(bus.out_flags),   64'(flg));
    chk({tag, "_illegal"}, 64'(bus.out_illegal), 64'(ill));
  endtask

  // Presents one op and lets it be accepted at the next rising edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    #1;
    chk("in_ready_at_issue", 64'(bus.in_ready), 64'(1'b1));
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic [3:0] flg);
    issue(op, a, b);
`ifdef EXEC_ALU_MULDIV_EN
    chk({tag, "_busy"}, 64'({bus.out_valid, bus.in_ready}), 64'(2'b00));
    for (int i = 1; i < XLEN; i++) begin
      cyc();
      chk({tag, "_busy"}, 64'({bus.out_valid, bus.in_ready}), 64'(2'b00));
    end
    cyc();
    chk_out(tag, res, flg, 1'b0);
`else
    chk_out(tag, 32'h0, 4'b0001, 1'b1);
`endif
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'd0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    // Reset state
    cyc();
    cyc();
    chk("rst_in_ready",  64'(bus.in_ready),    64'(1'b0));
    chk("rst_out_valid", 64'(bus.out_valid),   64'(1'b0));
    chk("rst_result",    64'(bus.out_result),  64'(0));
    chk("rst_flags",     64'(bus.out_flags),   64'(0));
    chk("rst_illegal",   64'(bus.out_illegal), 64'(1'b0));
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1'b1));
    cyc();

    // Single-cycle ops
    issue(4'd0, 32'hFFFF_FFFF, 32'h1);
    chk_out("add_wrap", 32'h0, 4'b0011, 1'b0);
    issue(4'd1, 32'h8000_0000, 32'h1);
    chk_out("sub_ovf", 32'h7FFF_FFFF, 4'b0110, 1'b0);
    issue(4'd7, 32'h8000_0000, 32'd4);
    chk_out("sra", 32'hF800_0000, 4'b1000, 1'b0);
    issue(4'd6, 32'h8000_0000, 32'd4);
    chk_out("srl", 32'h0800_0000, 4'b0000, 1'b0);
    issue(4'd5, 32'h1, 32'd33);   // only the low 5 bits of the shift count count
    chk_out("sll_mask", 32'h2, 4'b0000, 1'b0);
    issue(4'd4, 32'h0000_F0F0, 32'h0000_FF00);
    chk_out("xor", 32'h0000_0FF0, 4'b0000, 1'b0);
    issue(4'd8, 32'hFFFF_FFFF, 32'h1);
    chk_out("slt", 32'h1, 4'b0000, 1'b0);
    issue(4'd9, 32'hFFFF_FFFF, 32'h1);
    chk_out("sltu", 32'h0, 4'b0001, 1'b0);
    issue(4'd14, 32'h1234, 32'h5678);
    chk_out("reserved", 32'h0, 4'b0001, 1'b1);
    cyc();
    chk("drain_valid", 64'(bus.out_valid), 64'(1'b0));

    // Back-to-back with out_ready high: one result per cycle
    bus.in_valid = 1'b1; bus.in_op = 4'd0; bus.in_a = 32'd1; bus.in_b = 32'd2;
    cyc();
    bus.in_a = 32'd3; bus.in_b = 32'd4;
    chk_out("b2b_first", 32'd3, 4'b0000, 1'b0);
    cyc();
    bus.in_valid = 1'b0;
    chk_out("b2b_second", 32'd7, 4'b0000, 1'b0);
    cyc();
    chk("b2b_drain", 64'(bus.out_valid), 64'(1'b0));

    // Stall: second ADD waits while the first result is held
    issue(4'd0, 32'd10, 32'd20);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_op = 4'd0; bus.in_a = 32'd5; bus.in_b = 32'd6;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", 64'(bus.in_ready), 64'(1'b0));
      chk_out("stall_hold", 32'd30, 4'b0000, 1'b0);
      cyc();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("stall_release_ready", 64'(bus.in_ready), 64'(1'b1));
    cyc();
    bus.in_valid = 1'b0;
    chk_out("stall_second", 32'd11, 4'b0000, 1'b0);
    cyc();
    chk("stall_no_dup", 64'(bus.out_valid), 64'(1'b0));

    // Multi-cycle ops
    run_md("mul",   4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000);
    run_md("mulhu", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b1000);
    run_md("divu",  4'd12, 32'd100, 32'd7, 32'd14, 4'b0000);
    run_md("remu",  4'd13, 32'd100, 32'd7, 32'd2,  4'b0000);
    run_md("divu0", 4'd12, 32'd5, 32'd0, 32'hFFFF_FFFF, 4'b1000);
    run_md("remu0", 4'd13, 32'd5, 32'd0, 32'd5, 4'b0000);

    // Reset in the middle of a divide
    issue(4'd12, 32'd100, 32'd7);
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("midrst_ready_low", 64'(bus.in_ready), 64'(1'b0));
    cyc();
    rst = 1'b0;
    #1;
    chk("midrst_valid",  64'(bus.out_valid),  64'(1'b0));
    chk("midrst_result", 64'(bus.out_result), 64'(0));
    chk("midrst_ready",  64'(bus.in_ready),   64'(1'b1));
    cyc();
    issue(4'd0, 32'd2, 32'd3);
    chk_out("midrst_add", 32'd5, 4'b0000, 1'b0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
